// File: rtl/regfile_pkg.sv
// ============================================================
// regfile_pkg : shared constants and dump-state encoding
// Rev 1.0
// ============================================================
`default_nettype none

package regfile_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;

  typedef enum logic [0:0] {
    DUMP_IDLE = 1'b0,
    DUMP_SEND = 1'b1
  } dump_state_e;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_dump_fsm.sv
// ============================================================
// regfile_dump_fsm : valid/ready sequencer walking every register index
// Rev 1.0
// ============================================================
`default_nettype none

module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter  int NREG = NREG_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dump_req_i,
  input  logic          dump_ready_i,
  output logic          dump_valid_o,
  output logic [AW-1:0] dump_idx_o,
  output logic          dump_done_o
);

  dump_state_e   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      DUMP_IDLE: begin
        if (dump_req_i) begin
          state_d = DUMP_SEND;
          idx_d   = '0;
        end
      end
      DUMP_SEND: begin
        // Index only advances on a handshake, so it is stable while stalled.
        if (dump_ready_i) begin
          if (idx_q == AW'(NREG - 1)) begin
            state_d = DUMP_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      default: state_d = DUMP_IDLE;
    endcase
  end

  assign dump_valid_o = (state_q == DUMP_SEND);
  assign dump_idx_o   = idx_q;
  assign dump_done_o  = done_q;

endmodule : regfile_dump_fsm

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================
// regfile_sb : NREG x XLEN register file, x0 = 0, write bypass,
//              pending-write scoreboard and streaming dump port
// Rev 1.0
// ============================================================
`default_nettype none

module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [NRD*AW-1:0] raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]    busy_o,
  input  logic              iss_i,
  input  logic [AW-1:0]     iss_addr_i,
  input  logic              dump_req_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [AW-1:0]     dump_idx_o,
  output logic [XLEN-1:0]   dump_data_o,
  output logic              dump_done_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] sb_q, sb_d;
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  // x0 is never written, so its entry holds the reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Issue is applied after the clear so a same-cycle new producer stays pending.
  always_comb begin
    sb_d = sb_q;
    if (we_i)  sb_d[waddr_i]    = 1'b0;
    if (iss_i) sb_d[iss_addr_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sb_q <= '0;
    else      sb_q <= sb_d;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    assign ra  = raddr_i[k*AW +: AW];
    assign hit = we_i && (waddr_i == ra);
    always_comb begin
      if (ra == '0)  rdata_o[k*XLEN +: XLEN] = '0;
      else if (hit)  rdata_o[k*XLEN +: XLEN] = wdata_i;
      else           rdata_o[k*XLEN +: XLEN] = regs_q[ra];
    end
    assign busy_o[k] = sb_q[ra] && !hit;
  end

  regfile_dump_fsm #(
    .NREG (NREG)
  ) u_dump (
    .clk          (clk),
    .rst          (rst),
    .dump_req_i   (dump_req_i),
    .dump_ready_i (dump_ready_i),
    .dump_valid_o (dump_valid_o),
    .dump_idx_o   (dump_idx_o),
    .dump_done_o  (dump_done_o)
  );

  assign dump_data_o = regs_q[dump_idx_o];

endmodule : regfile_sb

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================
// tb_regfile_sb : directed self-checking bench for regfile_sb
// Rev 1.0
// ============================================================
`default_nettype none

module tb_regfile_sb;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              we = 1'b0;
  logic [AW-1:0]     waddr = '0;
  logic [XLEN-1:0]   wdata = '0;
  logic [AW-1:0]     ra0 = '0, ra1 = '0;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [XLEN-1:0]   rd0, rd1;
  logic [NRD-1:0]    busy;
  logic              iss = 1'b0;
  logic [AW-1:0]     iss_addr = '0;
  logic              dump_req = 1'b0;
  logic              dump_valid;
  logic              dump_ready = 1'b0;
  logic [AW-1:0]     dump_idx;
  logic [XLEN-1:0]   dump_data;
  logic              dump_done;

  int checks = 0;
  int failures = 0;
  logic [XLEN-1:0] exp_reg [NREG];

  assign raddr = {ra1, ra0};
  assign rd0   = rdata[0 +: XLEN];
  assign rd1   = rdata[XLEN +: XLEN];

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk          (clk),
    .rst          (rst),
    .we_i         (we),
    .waddr_i      (waddr),
    .wdata_i      (wdata),
    .raddr_i      (raddr),
    .rdata_o      (rdata),
    .busy_o       (busy),
    .iss_i        (iss),
    .iss_addr_i   (iss_addr),
    .dump_req_i   (dump_req),
    .dump_valid_o (dump_valid),
    .dump_ready_i (dump_ready),
    .dump_idx_o   (dump_idx),
    .dump_data_o  (dump_data),
    .dump_done_o  (dump_done)
  );

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NREG; i++) begin
      ra0 = AW'(i);
      ra1 = AW'(NREG - 1 - i);
      #1;
      checks++;
      if (rd0 !== '0 || rd1 !== '0 || busy !== 2'b00) begin
        failures++;
        $display("FAIL reset_read addr=%0d rd0=%h rd1=%h busy=%b required 0/0/00", i, rd0, rd1, busy);
      end
    end
    checks++;
    if (dump_valid !== 1'b0 || dump_idx !== '0 || dump_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_dump valid=%b idx=%0d done=%b required 0/0/0", dump_valid, dump_idx, dump_done);
    end
    rst = 1'b1;
  endtask

  task automatic test_write_bypass();
    @(posedge clk); #1;
    we = 1'b1; waddr = 5; wdata = 64'hDEAD_BEEF; ra0 = 5; ra1 = 0;
    #1;
    checks++;
    if (rd0 !== 64'hDEAD_BEEF || rd1 !== '0) begin
      failures++;
      $display("FAIL bypass_x5 rd0=%h rd1=%h required deadbeef/0", rd0, rd1);
    end
    @(posedge clk); #1;
    we = 1'b0; ra1 = 5;
    #1;
    checks++;
    if (rd0 !== 64'hDEAD_BEEF || rd1 !== 64'hDEAD_BEEF) begin
      failures++;
      $display("FAIL stored_x5 rd0=%h rd1=%h required deadbeef", rd0, rd1);
    end
    we = 1'b1; waddr = 0; wdata = 64'h1234; ra0 = 0;
    #1;
    checks++;
    if (rd0 !== '0) begin
      failures++;
      $display("FAIL x0_same_cycle rd0=%h required 0", rd0);
    end
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    checks++;
    if (rd0 !== '0) begin
      failures++;
      $display("FAIL x0_after_write rd0=%h required 0", rd0);
    end
  endtask

  task automatic test_scoreboard();
    @(posedge clk); #1;
    iss = 1'b1; iss_addr = 7;
    @(posedge clk); #1;
    iss = 1'b0; ra0 = 7; ra1 = 9;
    #1;
    checks++;
    if (busy !== 2'b01) begin
      failures++;
      $display("FAIL busy_x7_set busy=%b required 01", busy);
    end
    we = 1'b1; waddr = 7; wdata = 64'h77;
    #1;
    checks++;
    if (busy[0] !== 1'b0 || rd0 !== 64'h77) begin
      failures++;
      $display("FAIL busy_x7_bypass busy0=%b rd0=%h required 0/77", busy[0], rd0);
    end
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    checks++;
    if (busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL busy_x7_cleared busy0=%b required 0", busy[0]);
    end
    iss = 1'b1; iss_addr = 9; we = 1'b1; waddr = 9; wdata = 64'h99;
    @(posedge clk); #1;
    iss = 1'b0; we = 1'b0;
    #1;
    checks++;
    if (busy[1] !== 1'b1 || rd1 !== 64'h99) begin
      failures++;
      $display("FAIL iss_wins_x9 busy1=%b rd1=%h required 1/99", busy[1], rd1);
    end
    iss = 1'b1; iss_addr = 0;
    @(posedge clk); #1;
    iss = 1'b0; ra0 = 0;
    #1;
    checks++;
    if (busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL x0_never_busy busy0=%b required 0", busy[0]);
    end
    // Retire x9 so later phases start with a clean scoreboard.
    we = 1'b1; waddr = 9; wdata = 64'h99;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic test_dump_full();
    exp_reg[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = XLEN'(i); exp_reg[i] = XLEN'(i);
      @(posedge clk); #1;
    end
    we = 1'b0;
    dump_ready = 1'b1; dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    #1;
    for (int i = 0; i < NREG; i++) begin
      checks++;
      if (dump_valid !== 1'b1 || dump_idx !== AW'(i) || dump_data !== XLEN'(i) || dump_done !== 1'b0) begin
        failures++;
        $display("FAIL dump_beat i=%0d valid=%b idx=%0d data=%h done=%b required 1/%0d/%0d/0",
                 i, dump_valid, dump_idx, dump_data, dump_done, i, i);
      end
      @(posedge clk); #2;
    end
    checks++;
    if (dump_done !== 1'b1 || dump_valid !== 1'b0) begin
      failures++;
      $display("FAIL dump_done_pulse done=%b valid=%b required 1/0", dump_done, dump_valid);
    end
    // Request held on the done cycle restarts the dump at once.
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    #1;
    checks++;
    if (dump_done !== 1'b0 || dump_valid !== 1'b1 || dump_idx !== '0) begin
      failures++;
      $display("FAIL dump_restart done=%b valid=%b idx=%0d required 0/1/0", dump_done, dump_valid, dump_idx);
    end
    repeat (NREG) @(posedge clk);
    #2;
    checks++;
    if (dump_done !== 1'b1) begin
      failures++;
      $display("FAIL dump_restart_done done=%b required 1", dump_done);
    end
    @(posedge clk); #2;
    checks++;
    if (dump_done !== 1'b0 || dump_valid !== 1'b0) begin
      failures++;
      $display("FAIL dump_done_one_cycle done=%b valid=%b required 0/0", dump_done, dump_valid);
    end
  endtask

  task automatic test_dump_stall();
    int  e;
    int  cyc;
    bit  rdy;
    bit  wrote;
    bit  wr_now;
    e = 0; cyc = 0; wrote = 1'b0;
    dump_ready = 1'b0; dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    while (e < NREG && cyc < 200) begin
      #1;
      checks++;
      if (dump_valid !== 1'b1 || dump_idx !== AW'(e) || dump_data !== exp_reg[e] || dump_done !== 1'b0) begin
        failures++;
        $display("FAIL stall_beat cyc=%0d valid=%b idx=%0d data=%h done=%b required 1/%0d/%h/0",
                 cyc, dump_valid, dump_idx, dump_data, dump_done, e, exp_reg[e]);
      end
      rdy = (cyc % 2) == 1;
      dump_ready = rdy;
      wr_now = (e == 1) && !wrote;
      if (wr_now) begin
        we = 1'b1; waddr = 3; wdata = 64'hAA; wrote = 1'b1;
      end
      @(posedge clk); #1;
      we = 1'b0;
      if (wr_now) exp_reg[3] = 64'hAA;
      if (rdy) e++;
      cyc++;
    end
    #1;
    checks++;
    if (e != NREG || dump_done !== 1'b1 || dump_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_done accepts=%0d done=%b valid=%b required %0d/1/0", e, dump_done, dump_valid, NREG);
    end
    dump_ready = 1'b1;
  endtask

  task automatic test_reset_mid_dump();
    @(posedge clk); #1;
    dump_ready = 1'b1; dump_req = 1'b1; iss = 1'b1; iss_addr = 12;
    @(posedge clk); #1;
    dump_req = 1'b0; iss = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (dump_valid !== 1'b1 || dump_idx !== AW'(10)) begin
      failures++;
      $display("FAIL mid_dump_pos valid=%b idx=%0d required 1/10", dump_valid, dump_idx);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (dump_valid !== 1'b0 || dump_idx !== '0 || dump_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_dump valid=%b idx=%0d done=%b required 0/0/0", dump_valid, dump_idx, dump_done);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      checks++;
      if (dump_done !== 1'b0 || dump_valid !== 1'b0) begin
        failures++;
        $display("FAIL no_done_after_reset cyc=%0d done=%b valid=%b required 0/0", c, dump_done, dump_valid);
      end
    end
    for (int i = 0; i < NREG; i++) begin
      ra0 = AW'(i);
      ra1 = 12;
      #1;
      checks++;
      if (rd0 !== '0 || busy !== 2'b00) begin
        failures++;
        $display("FAIL reset_cleared addr=%0d rd0=%h busy=%b required 0/00", i, rd0, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_scoreboard();
    test_dump_full();
    test_dump_stall();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule : tb_regfile_sb

`default_nettype wire
